// File: rtl/dispatch_scheduler_pkg.sv
// Shared definitions for the dispatch scheduler.
// Contents:
//   - RV32 base opcode constants
//   - instruction field bit positions
//   - task-class enum and the classify() helper, which maps an opcode to the
//     execution channel that serves it
package dispatch_scheduler_pkg;

  localparam int INS_W = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  typedef enum logic {
    TASK_ALU = 1'b0,
    TASK_MEM = 1'b1
  } task_class_e;

  // Loads and stores go to the MEM unit. Everything else, including
  // unrecognised opcodes, goes to the ALU. Illegal encodings are trapped
  // further down the pipe, not here.
  function automatic task_class_e classify(input logic [6:0] opc);
    if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
      return TASK_MEM;
    end
    return TASK_ALU;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Circular buffer used as the in-order issue queue.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset (clears pointers and count)
//   clear_i  drop all entries (head jumps to tail, count to 0)
//   push_i   write data_i at tail (ignored when full or clearing)
//   pop_i    advance head (ignored when empty or clearing)
//   data_i   entry to write
//   data_o   entry at head (contents are stale when empty_o is high)
//   full_o   count == DEPTH
//   empty_o  count == 0
//   count_o  occupancy
module dispatch_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 37,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[head_q];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is data only; validity is tracked by the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[tail_q] <= data_i;
    end
  end

endmodule

// File: rtl/dispatch_scheduler.sv
// In-order issue buffer between fetch and the execution units.
// Tags incoming instructions with a wrapping id, queues them, decodes the
// head entry and offers it on the ALU or MEM channel.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   rdy_in                    global ready; low freezes all state
//   flush_pipeline            drop every queued instruction
//   ins_valid, ins_in         fetch handshake / instruction word
//   ins_ready                 queue not full (registered count only)
//   opcode, funct3, funct7    decoded fields of the head (0 when empty)
//   ins_word, ins_id          head word and tag (0 when empty)
//   alu_task_valid/alu_accept ALU channel handshake
//   mem_task_valid/mem_accept MEM channel handshake
//   count                     queue occupancy
module dispatch_scheduler
  import dispatch_scheduler_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ID_WIDTH  = 5,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_pipeline,
  input  logic                 ins_valid,
  input  logic [31:0]          ins_in,
  output logic                 ins_ready,
  output logic [6:0]           opcode,
  output logic [2:0]           funct3,
  output logic [6:0]           funct7,
  output logic [31:0]          ins_word,
  output logic [ID_WIDTH-1:0]  ins_id,
  output logic                 alu_task_valid,
  input  logic                 alu_accept,
  output logic                 mem_task_valid,
  input  logic                 mem_accept,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int ENTRY_W = INS_W + ID_WIDTH;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dispatch_scheduler: DEPTH must be a power of two >= 2");
    end
    if (DEPTH > (2 ** ID_WIDTH)) begin : g_bad_id
      $error("dispatch_scheduler: DEPTH must not exceed 2**ID_WIDTH");
    end
  endgenerate

  logic [ID_WIDTH-1:0] next_id_q, next_id_d;
  logic [ENTRY_W-1:0]  head_entry;
  logic [INS_W-1:0]    head_word;
  logic [ID_WIDTH-1:0] head_tag;
  logic                q_full, q_empty;
  logic                enqueue, dispatch, clear;
  logic                offer_ok;
  task_class_e         head_class;

  dispatch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W),
    .CNT_W  (CNT_WIDTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .clear_i (clear),
    .push_i  (enqueue),
    .pop_i   (dispatch),
    .data_i  ({ins_in, next_id_q}),
    .data_o  (head_entry),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (count)
  );

  assign head_word  = head_entry[ID_WIDTH +: INS_W];
  assign head_tag   = head_entry[ID_WIDTH-1:0];
  assign head_class = classify(head_word[OPC_MSB:OPC_LSB]);

  // ins_ready looks only at the registered count, so a full queue never
  // accepts in the cycle it dispatches.
  assign ins_ready = ~q_full;

  // Offers are withheld while paused or flushing; rdy_in low also blocks
  // the flush itself, so a held flush takes effect once rdy_in returns.
  assign offer_ok       = ~q_empty & rdy_in & ~flush_pipeline;
  assign alu_task_valid = offer_ok & (head_class == TASK_ALU);
  assign mem_task_valid = offer_ok & (head_class == TASK_MEM);

  assign dispatch = (alu_task_valid & alu_accept) | (mem_task_valid & mem_accept);
  assign enqueue  = ins_valid & ins_ready & rdy_in & ~flush_pipeline;
  assign clear    = flush_pipeline & rdy_in;

  always_comb begin
    opcode   = '0;
    funct3   = '0;
    funct7   = '0;
    ins_word = '0;
    ins_id   = '0;
    if (!q_empty) begin
      opcode   = head_word[OPC_MSB:OPC_LSB];
      funct3   = head_word[F3_MSB:F3_LSB];
      funct7   = head_word[F7_MSB:F7_LSB];
      ins_word = head_word;
      ins_id   = head_tag;
    end
  end

  // Tags are not rewound on flush so ids stay unique across it.
  always_comb begin
    next_id_d = next_id_q;
    if (enqueue) next_id_d = next_id_q + ID_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      next_id_q <= '0;
    end else begin
      next_id_q <= next_id_d;
    end
  end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences.
module tb_dispatch_scheduler;

  localparam int DEPTH = 8;
  localparam int IDW   = 5;
  localparam int CNTW  = $clog2(DEPTH + 1);

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] SRA  = 32'h4020D1B3;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in, flush_pipeline, ins_valid;
  logic [31:0]     ins_in;
  logic            ins_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     ins_word;
  logic [IDW-1:0]  ins_id;
  logic            alu_task_valid, alu_accept, mem_task_valid, mem_accept;
  logic [CNTW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  dispatch_scheduler #(.DEPTH(DEPTH), .ID_WIDTH(IDW)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush_pipeline (flush_pipeline),
    .ins_valid      (ins_valid),
    .ins_in         (ins_in),
    .ins_ready      (ins_ready),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .ins_word       (ins_word),
    .ins_id         (ins_id),
    .alu_task_valid (alu_task_valid),
    .alu_accept     (alu_accept),
    .mem_task_valid (mem_task_valid),
    .mem_accept     (mem_accept),
    .count          (count)
  );

  typedef struct {
    logic        rst, rdy, flush, iv;
    logic [31:0] ins;
    logic        aa, ma;
    int          cnt;
    logic        rdy_o, av, mv;
    logic [6:0]  opc;
    int          id;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, rdy, flush, iv, input logic [31:0] ins,
                              input logic aa, ma, input int cnt, input logic rdy_o, av, mv,
                              input logic [6:0] opc, input int id);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.flush = flush; v.iv = iv; v.ins = ins;
    v.aa = aa; v.ma = ma; v.cnt = cnt; v.rdy_o = rdy_o; v.av = av; v.mv = mv;
    v.opc = opc; v.id = id;
    return v;
  endfunction

  function automatic logic [31:0] addi(input int k);
    return 32'h00000093 | (32'(k & 12'hFFF) << 20);
  endfunction

  task automatic idle_inputs();
    rst_in = 1'b0; rdy_in = 1'b1; flush_pipeline = 1'b0; ins_valid = 1'b0;
    ins_in = '0; alu_accept = 1'b0; mem_accept = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    ins_valid = 1'b1; ins_in = w;
    @(negedge clk_in);
    ins_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Expected values are the outputs seen during the cycle, before its edge.
    //              rst rdy fl iv ins   aa ma  cnt rdy av mv opc    id
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0)); // reset state
    vecs.push_back(mk(0, 1, 0, 1, ADDI, 0, 0,  0,  1,  0, 0, 7'h00, 0)); // no bypass
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  1,  1,  1, 0, 7'h13, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  1,  1,  1, 0, 7'h13, 0)); // held
    vecs.push_back(mk(0, 1, 0, 0, 0,    1, 0,  1,  1,  1, 0, 7'h13, 0)); // accepted
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0)); // reset ids
    vecs.push_back(mk(0, 1, 0, 1, LW,   1, 1,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 1, 0, 1, ADD,  1, 1,  1,  1,  0, 1, 7'h03, 0)); // LW first
    vecs.push_back(mk(0, 1, 0, 0, 0,    1, 1,  1,  1,  1, 0, 7'h33, 1)); // then ADD
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 1, 0, 1, SW,   0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,    1, 0,  1,  1,  0, 1, 7'h23, 2)); // wrong channel
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 1,  1,  1,  0, 1, 7'h23, 2));
    vecs.push_back(mk(0, 1, 0, 1, ADDI, 0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 0, 0, 1, ADD,  1, 1,  1,  1,  0, 0, 7'h13, 3)); // paused x3
    vecs.push_back(mk(0, 0, 0, 1, ADD,  1, 1,  1,  1,  0, 0, 7'h13, 3));
    vecs.push_back(mk(0, 0, 0, 1, ADD,  1, 1,  1,  1,  0, 0, 7'h13, 3));
    vecs.push_back(mk(0, 0, 1, 1, ADD,  1, 1,  1,  1,  0, 0, 7'h13, 3)); // flush ignored
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  1,  1,  1, 0, 7'h13, 3));
    vecs.push_back(mk(0, 1, 1, 1, ADD,  1, 0,  1,  1,  0, 0, 7'h13, 3)); // flush
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 1, 0, 1, ADD,  0, 0,  0,  1,  0, 0, 7'h00, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,    1, 0,  1,  1,  1, 0, 7'h33, 4)); // id kept
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  0,  1,  0, 0, 7'h00, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_in = vecs[i].rst; rdy_in = vecs[i].rdy; flush_pipeline = vecs[i].flush;
      ins_valid = vecs[i].iv; ins_in = vecs[i].ins;
      alu_accept = vecs[i].aa; mem_accept = vecs[i].ma;
      #1;
      chk($sformatf("v%0d count", i), 32'(count), vecs[i].cnt);
      chk($sformatf("v%0d ins_ready", i), 32'(ins_ready), 32'(vecs[i].rdy_o));
      chk($sformatf("v%0d alu_valid", i), 32'(alu_task_valid), 32'(vecs[i].av));
      chk($sformatf("v%0d mem_valid", i), 32'(mem_task_valid), 32'(vecs[i].mv));
      chk($sformatf("v%0d opcode", i), 32'(opcode), 32'(vecs[i].opc));
      chk($sformatf("v%0d ins_id", i), 32'(ins_id), vecs[i].id);
      @(negedge clk_in);
    end

    // Full queue: 9th push dropped, no accept while full, ids continue at 8.
    do_reset();
    for (int k = 0; k < 8; k++) push(addi(k));
    #1;
    chk("full count", 32'(count), 8);
    chk("full ins_ready", 32'(ins_ready), 0);
    chk("full head id", 32'(ins_id), 0);
    @(negedge clk_in);
    push(addi(99));
    #1;
    chk("drop count", 32'(count), 8);
    @(negedge clk_in);
    alu_accept = 1'b1; ins_valid = 1'b1; ins_in = addi(8);
    @(negedge clk_in);
    alu_accept = 1'b0;
    #1;
    chk("deq-while-full count", 32'(count), 7);
    chk("deq-while-full ready", 32'(ins_ready), 1);
    @(negedge clk_in);
    ins_valid = 1'b0;
    #1;
    chk("refill count", 32'(count), 8);
    @(negedge clk_in);
    alu_accept = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("drain id %0d", k), 32'(ins_id), k);
      chk($sformatf("drain word %0d", k), ins_word, addi(k));
      @(negedge clk_in);
    end
    alu_accept = 1'b0;
    #1;
    chk("drained count", 32'(count), 0);
    @(negedge clk_in);

    // 40 instructions streamed through with a stuttering accept.
    begin
      logic [31:0] mq[$];
      int pushed = 0, popped = 0, cyc = 0;
      logic dp, dq;
      do_reset();
      while (popped < 40 && cyc < 400) begin
        ins_valid = (pushed < 40);
        ins_in = addi(pushed);
        alu_accept = ((cyc % 3) != 2);
        #1;
        chk("wrap count", 32'(count), mq.size());
        if (mq.size() > 0) begin
          chk("wrap alu_valid", 32'(alu_task_valid), 1);
          if (alu_accept) begin
            chk("wrap id", 32'(ins_id), popped % 32);
            chk("wrap word", ins_word, mq[0]);
          end
        end
        dp = ins_valid && (mq.size() < DEPTH);
        dq = alu_accept && (mq.size() > 0);
        @(negedge clk_in);
        if (dq) begin void'(mq.pop_front()); popped++; end
        if (dp) begin mq.push_back(addi(pushed)); pushed++; end
        cyc++;
      end
      chk("wrap completed", popped, 40);
      idle_inputs();
    end

    // Flush with 5 entries while pushing and accepting.
    do_reset();
    push(SRA);
    for (int k = 1; k < 5; k++) push(addi(k));
    #1;
    chk("pre-flush count", 32'(count), 5);
    chk("pre-flush funct3", 32'(funct3), 5);
    chk("pre-flush funct7", 32'(funct7), 32'h20);
    chk("pre-flush opcode", 32'(opcode), 32'h33);
    @(negedge clk_in);
    flush_pipeline = 1'b1; ins_valid = 1'b1; ins_in = ADDI; alu_accept = 1'b1;
    #1;
    chk("flush alu_valid", 32'(alu_task_valid), 0);
    @(negedge clk_in);
    idle_inputs();
    #1;
    chk("post-flush count", 32'(count), 0);
    chk("post-flush alu_valid", 32'(alu_task_valid), 0);
    chk("post-flush mem_valid", 32'(mem_task_valid), 0);
    chk("post-flush word", ins_word, 0);
    @(negedge clk_in);
    push(LW);
    #1;
    chk("post-flush id", 32'(ins_id), 5);
    chk("post-flush mem offer", 32'(mem_task_valid), 1);
    @(negedge clk_in);

    // Reset with 4 queued while paused.
    for (int k = 0; k < 4; k++) push(addi(k));
    rst_in = 1'b1; rdy_in = 1'b0;
    @(negedge clk_in);
    idle_inputs();
    #1;
    chk("rst count", 32'(count), 0);
    chk("rst ins_ready", 32'(ins_ready), 1);
    @(negedge clk_in);
    push(ADD);
    #1;
    chk("rst next id", 32'(ins_id), 0);
    chk("rst next count", 32'(count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dispatch_scheduler.md
Name: dispatch_scheduler

Overview:
Parametrised in-order issue buffer between instruction fetch and the execution units. It accepts raw 32-bit instructions and tags each with a wrapping instruction id. It buffers them in a circular queue of DEPTH entries, decodes the head entry and dispatches it to either the ALU channel or the MEM channel over a valid/accept handshake. The whole queue is flushed on a pipeline flush (mispredict or exception).

Parameters:
DEPTH, 8, queue entries; power of two, at least 2.
ID_WIDTH, 5, width of instruction id tag; DEPTH <= 2**ID_WIDTH (elaboration-time check).
CNT_WIDTH, $clog2(DEPTH+1), width of occupancy count.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
rdy_in  input  1  global ready; low = pause
flush_pipeline  input  1  discard all buffered instructions
ins_valid  input  1  fetch presents an instruction this cycle
ins_in  input  32  raw instruction word
ins_ready  output  1  queue can accept (not full)
opcode  output  7  head ins_in[6:0]
funct3  output  3  head ins_in[14:12]
funct7  output  7  head ins_in[31:25]
ins_word  output  32  head raw instruction
ins_id  output  ID_WIDTH  head tag
alu_task_valid  output  1  head is an ALU-class instruction, offered
alu_accept  input  1  ALU takes the head this cycle
mem_task_valid  output  1  head is a MEM-class instruction, offered
mem_accept  input  1  MEM unit takes the head this cycle
count  output  CNT_WIDTH  current occupancy

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset has absolute priority and acts regardless of rdy_in. It clears head, tail, count and next_id to 0.
- After reset: ins_ready=1, alu_task_valid=0, mem_task_valid=0. All decoded outputs are 0.
- Decoded outputs come combinationally from the registered head entry. When empty: decoded outputs are 0 and both valids are 0.
- Classification of the head entry:
  - opcode 0000011 (LOAD) or 0100011 (STORE) is MEM class.
  - Every other opcode is ALU class. No illegal-opcode trap here.
- Valid rules:
  - alu_task_valid = !empty & ALU class & rdy_in & !flush_pipeline.
  - mem_task_valid = !empty & MEM class & rdy_in & !flush_pipeline.
  - At most one valid is high in any cycle.
- Dispatch (dequeue) = (alu_task_valid & alu_accept) | (mem_task_valid & mem_accept). On dispatch the head advances by 1, modulo DEPTH.
  - Accept on the non-offered channel is ignored.
  - Strictly in order: a blocked head stalls everything behind it.
- ins_ready = (count != DEPTH). Enqueue = ins_valid & ins_ready & rdy_in & !flush_pipeline.
  - Enqueue writes {ins_in, next_id} at tail. Tail advances mod DEPTH; next_id increments mod 2**ID_WIDTH (wraps 31->0 at default).
  - Enqueue while full is dropped; the upstream must hold the instruction.
  - A full queue does not accept in the same cycle it dispatches: ins_ready depends on the registered count only.
- Simultaneous enqueue and dispatch: count is unchanged, and both pointers advance.
- Empty queue: a new instruction is visible at the head on the cycle after enqueue. Latency in to offer is 1 cycle; there is no bypass.
- rdy_in low: no state changes (no enqueue, dispatch, or flush), both valids forced 0, ins_ready still reflects count.
- flush_pipeline with rdy_in high:
  - Next cycle count=0 and head=tail.
  - Enqueue and dispatch in that cycle are suppressed.
  - next_id is NOT reset, so tags stay unique across the flush.
- Flush asserted while rdy_in low is ignored. The upstream holds the flush until rdy_in is high.

Decomposition:
- Shared package:
  - opcode localparams: OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC.
  - Field bit-range constants.
  - Task-class enum {TASK_ALU, TASK_MEM}.
  - Helper function classify(opcode).
- One sub-module, dispatch_fifo: circular buffer with push/pop/clear, full, empty and count, parametrised by DEPTH and data width (32+ID_WIDTH). dispatch_scheduler adds id allocation, decode and handshake.

Test Plan:
- Reset, then push ADDI 0x00500093 with alu_accept=0 -> next cycle alu_task_valid=1, mem_task_valid=0, opcode=0010011, ins_id=0, count=1; held until alu_accept=1, then count=0.
- Push LW 0x0000A103 then ADD 0x002081B3, mem_accept=1, alu_accept=1 -> mem_task_valid with ins_id=0 first, then alu_task_valid with ins_id=1. Head ALU is never offered before the LW leaves.
- Push 8 instructions with no accepts -> count=8, ins_ready=0; a 9th push is ignored. One dispatch plus a push in the following cycle -> count stays 8, ids continue at 8.
- Issue 40 instructions through the queue -> ins_id sequence 0..31,0..7. Pointer wrap preserves order.
- Fill 5 entries, assert flush_pipeline with ins_valid=1 and alu_accept=1 -> nothing dispatched or enqueued that cycle; next cycle count=0, both valids 0; the next push gets ins_id=5.
- Hold rdy_in=0 for 3 cycles with ins_valid=1 and accepts=1 -> count, ids and pointers unchanged, valids 0. Assert rst_in with 4 entries queued -> count=0 and next push gets ins_id=0.
